two_bit_demux_1to4: RTL and testbench
=====================================

# two_bit_demux_1to4

Buffered 1-to-4 demultiplexer: the distribution counterpart of the 2-bit 4-to-1 selector in the datapath. It accepts a WIDTH-bit value on a valid/ready input and steers it, by a 2-bit `decider`, into one of four independent one-entry holding slots. Each slot drains on its own valid/ready output channel. It sits between a single producer (control/ALU path) and four consumers (register-file write ports, PC sources and similar).

## Interface
- WIDTH, 2, data width per value
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  value to distribute
- in_valid  input  1  producer has a value
- in_ready  output  1  block accepts a value this cycle
- decider  input  2  destination channel 0..3, sampled in the accept cycle
- out_data  output  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- out_valid  output  4  slot i holds a value
- out_ready  input  4  consumer i takes its value
- out_count  output  32  per-channel delivered count, 8 bits per channel; present only with DEMUX_COUNT_EN

## Operation
- Each channel i has one slot with state EMPTY or FULL. out_valid[i] = 1 exactly when the slot is FULL.
- The input handshake is an accept: in_valid & in_ready at a rising edge.
- A drain on channel i is out_valid[i] & out_ready[i] at a rising edge.
- in_ready = ~reset & (~out_valid[decider] | out_ready[decider]). Only the selected slot matters; the other channels never stall the input.
- On accept, the slot at decider loads in_data and becomes FULL.
- Transitions per slot:
  - EMPTY to FULL on a load.
  - FULL to EMPTY on a drain without a load.
  - FULL stays FULL on a simultaneous drain and load. The old value is delivered and the new value replaces it.
- Unselected slots change state only by their own drain.
- out_data[i] holds its last loaded value while EMPTY. Consumers must ignore it then.
- Values never reorder within a channel. Across channels there is no ordering guarantee.
- While in_valid is high and in_ready is low, the producer may change decider. A stalled value may therefore retarget to a free channel. This is legal.

## Timing
- Reset values: out_valid = 4'b0000, out_data = all zeros, in_ready = 0 while reset is high, out_count = all zeros.
- Latency: a value accepted at edge N gives out_valid high from edge N onward, so it is visible in cycle N+1. Minimum delivery is the edge after that.
- Throughput: one value per cycle into a channel whose consumer holds out_ready high. The combinational ready pass-through gives zero bubbles.
- in_ready depends combinationally on decider and out_ready. out_valid and out_data are registered.
- Reset asserted mid-operation: all slots go EMPTY at that edge and buffered values are discarded. Handshakes in that cycle are ignored, including counter updates.
- All four channels may drain in the same cycle as one load.

## Configuration
- DEMUX_COUNT_EN defined:
  - out_count exists.
  - Each 8-bit field increments on every drain of its channel.
  - Each field wraps from 255 to 0.
  - Each field clears on reset.
- DEMUX_COUNT_EN undefined: the port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package two_bit_demux_pkg holds:
  - NUM_CH = 4
  - SEL_W = 2
  - COUNT_W = 8
  - the slot-state encoding EMPTY = 1'b0, FULL = 1'b1
- Sub-module demux_slot: one-entry holding register with load, drain, valid and data, instantiated four times. Top level holds the decider decode, in_ready logic and optional counters.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1 -> in_ready=0, out_valid=0000, out_data=0, out_count=0.
- Single route: decider=2, in_data=2'b11, out_ready=0000 -> after the accept edge out_valid=0100 and out_data[5:4]=11. Next value to decider=2 stalls (in_ready=0). decider=1 is accepted.
- Streaming: decider=3, out_ready[3]=1, data sequence 0,1,2,3 on consecutive cycles -> in_ready stays 1 and channel 3 delivers 0,1,2,3 in order with no bubble.
- Simultaneous drain and load: slot 0 FULL with 01, out_ready[0]=1, accept 10 to decider=0 -> consumer receives 01, then slot holds 10 with out_valid[0] still 1.
- Reset mid-operation: fill slots 0 and 2, assert reset one cycle while out_ready=1111 -> out_valid=0000, no delivery counted.
- DEMUX_COUNT_EN: 257 drains on channel 1 -> out_count[15:8]=1, other fields 0.

Source files
------------

// File: rtl/two_bit_demux_pkg.sv
// two_bit_demux_pkg
//   Shared constants and types for the buffered 1-to-4 demultiplexer.
//   NUM_CH  : number of output channels
//   SEL_W   : width of the channel selector
//   COUNT_W : width of each per-channel delivered counter
//   slot_state_t : holding-slot occupancy (EMPTY / FULL)
package two_bit_demux_pkg;

   localparam int NUM_CH  = 4;
   localparam int SEL_W   = 2;
   localparam int COUNT_W = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   // One-hot decode of a channel selector.
   function automatic logic [NUM_CH-1:0] decode_sel(input logic [SEL_W-1:0] sel);
      logic [NUM_CH-1:0] one;
      one = 1;
      return one << sel;
   endfunction

endpackage

// File: rtl/two_bit_demux_1to4_slot.sv
// demux_slot
//   One-entry holding register for one demux output channel.
//   Ports:
//     clk      : rising-edge clock
//     reset    : synchronous active-high reset (slot EMPTY, data zero)
//     i_load   : write i_data into the slot this edge
//     i_drain  : consumer takes the held value this edge
//     i_data   : value to load
//     o_valid  : slot is FULL
//     o_data   : held value (last loaded value while EMPTY)
module demux_slot
   import two_bit_demux_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_drain,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   slot_state_t      r_state;
   slot_state_t      w_state_nxt;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk) begin
      if (reset) r_state <= EMPTY;
      else       r_state <= w_state_nxt;
   end

   // A load wins over a drain: on a simultaneous drain and load the old
   // value leaves and the new one takes its place, so the slot stays FULL.
   always_comb begin
      w_state_nxt = r_state;
      if (i_load)       w_state_nxt = FULL;
      else if (i_drain) w_state_nxt = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset)       r_data <= '0;
      else if (i_load) r_data <= i_data;
   end

   assign o_valid = (r_state == FULL);
   assign o_data  = r_data;

endmodule

// File: rtl/two_bit_demux_1to4.sv
// two_bit_demux_1to4
//   Buffered 1-to-4 demultiplexer. A value accepted on the in_valid/in_ready
//   handshake is steered by decider into one of four one-entry slots; each
//   slot drains on its own out_valid/out_ready channel.
//   Ports:
//     clk, reset : rising-edge clock, synchronous active-high reset
//     in_data    : value to distribute (WIDTH bits)
//     in_valid   : producer has a value
//     in_ready   : block accepts a value this cycle (combinational)
//     decider    : destination channel 0..3, sampled in the accept cycle
//     out_data   : channel i at bits [i*WIDTH +: WIDTH]
//     out_valid  : slot i holds a value
//     out_ready  : consumer i takes its value
//     out_count  : per-channel delivered count, 8 bits per channel
//                  (only when DEMUX_COUNT_EN is defined)
//   Optional feature macro: DEMUX_COUNT_EN
module two_bit_demux_1to4
   import two_bit_demux_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SEL_W-1:0]          decider,
   output logic [NUM_CH*WIDTH-1:0]   out_data,
   output logic [NUM_CH-1:0]         out_valid,
   input  logic [NUM_CH-1:0]         out_ready
`ifdef DEMUX_COUNT_EN
   ,
   output logic [NUM_CH*COUNT_W-1:0] out_count
`endif
);

   logic                          w_accept;
   logic [NUM_CH-1:0]             w_load;
   logic [NUM_CH-1:0]             w_drain;
   logic [NUM_CH-1:0][WIDTH-1:0]  w_slot_data;

   // Only the selected slot can stall the input; a FULL slot whose consumer
   // is taking its value this cycle frees up in time for the new load.
   assign in_ready = ~reset & (~out_valid[decider] | out_ready[decider]);
   assign w_accept = in_valid & in_ready;
   assign w_load   = decode_sel(decider) & {NUM_CH{w_accept}};
   assign w_drain  = out_valid & out_ready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk     (clk),
         .reset   (reset),
         .i_load  (w_load[i]),
         .i_drain (w_drain[i]),
         .i_data  (in_data),
         .o_valid (out_valid[i]),
         .o_data  (w_slot_data[i])
      );
      assign out_data[i*WIDTH +: WIDTH] = w_slot_data[i];
   end

`ifdef DEMUX_COUNT_EN
   logic [NUM_CH-1:0][COUNT_W-1:0] r_count;

   // Counters wrap naturally; reset takes priority so drains seen in a
   // reset cycle are never counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_drain[i]) r_count[i] <= r_count[i] + 1'b1;
         end
      end
   end

   assign out_count = r_count;
`endif

endmodule

// File: tb/tb_two_bit_demux_1to4.sv
module tb_two_bit_demux_1to4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  decider = '0;
   logic [7:0]  out_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = '0;
`ifdef DEMUX_COUNT_EN
   logic [31:0] out_count;
`endif

   int errors = 0;
   int checks = 0;

   // Scoreboard: per-channel queues of expected values, plus model occupancy.
   logic [1:0]  sbq [4][$];
   logic [3:0]  mv = '0;
   logic [7:0]  mcnt [4] = '{default: 8'd0};

   always #5 clk = ~clk;

   two_bit_demux_1to4 #(.WIDTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .decider   (decider),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef DEMUX_COUNT_EN
      ,
      .out_count (out_count)
`endif
   );

   // Monitor: at each active edge, check the handshake against the model,
   // pop/compare deliveries, push accepted values.
   always @(posedge clk) begin
      logic       exp_rdy;
      logic [1:0] exp_d;
      exp_rdy = !reset && (!mv[decider] || out_ready[decider]);
      checks++;
      if (in_ready !== exp_rdy) begin
         errors++;
         $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_rdy);
      end
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            sbq[i].delete();
            mcnt[i] = 8'd0;
         end
         mv = '0;
      end else begin
         checks++;
         if (out_valid !== mv) begin
            errors++;
            $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, out_valid, mv);
         end
         for (int i = 0; i < 4; i++) begin
            if (mv[i] && out_ready[i]) begin
               checks++;
               if (sbq[i].size() == 0) begin
                  errors++;
                  $display("FAIL sb_empty ch=%0d t=%0t got=%b exp=none", i, $time, out_data[i*2 +: 2]);
               end else begin
                  exp_d = sbq[i].pop_front();
                  if (out_data[i*2 +: 2] !== exp_d) begin
                     errors++;
                     $display("FAIL sb_data ch=%0d t=%0t got=%b exp=%b", i, $time, out_data[i*2 +: 2], exp_d);
                  end
               end
               mv[i] = 1'b0;
               mcnt[i] = mcnt[i] + 8'd1;
            end
         end
         if (in_valid && exp_rdy) begin
            sbq[decider].push_back(in_data);
            mv[decider] = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_data = 2'b11; decider = 2'd0; out_ready = '0;
      repeat (3) tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++;
      if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
      checks++;
      if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
`ifdef DEMUX_COUNT_EN
      checks++;
      if (out_count !== 32'h0) begin errors++; $display("FAIL reset_out_count got=%h exp=0", out_count); end
`endif
      in_valid = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_single_route();
      out_ready = 4'b0000; decider = 2'd2; in_data = 2'b11; in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 4'b0100) begin errors++; $display("FAIL route_valid got=%b exp=0100", out_valid); end
      checks++;
      if (out_data[5:4] !== 2'b11) begin errors++; $display("FAIL route_data got=%b exp=11", out_data[5:4]); end
      in_data = 2'b01;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL route_stall got=%b exp=0", in_ready); end
      decider = 2'd1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL route_retarget got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 4'b0110) begin errors++; $display("FAIL route_two_full got=%b exp=0110", out_valid); end
      out_ready = 4'b1111;
      tick();
      out_ready = 4'b0000;
      checks++;
      if (out_valid !== 4'b0000) begin errors++; $display("FAIL route_drained got=%b exp=0000", out_valid); end
   endtask

   task automatic test_streaming();
      logic [1:0] v;
      decider = 2'd3; out_ready = 4'b1000; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         v = k[1:0];
         in_data = v;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready); end
         tick();
         checks++;
         if (out_valid[3] !== 1'b1 || out_data[7:6] !== v) begin
            errors++;
            $display("FAIL stream_slot k=%0d got=%b/%b exp=1/%b", k, out_valid[3], out_data[7:6], v);
         end
      end
      in_valid = 1'b0;
      tick();
      out_ready = 4'b0000;
      checks++;
      if (out_valid !== 4'b0000) begin errors++; $display("FAIL stream_end got=%b exp=0000", out_valid); end
   endtask

   task automatic test_drain_and_load();
      out_ready = 4'b0000; decider = 2'd0; in_data = 2'b01; in_valid = 1'b1;
      tick();
      out_ready = 4'b0001; in_data = 2'b10;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dl_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0; out_ready = 4'b0000;
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[1:0] !== 2'b10) begin
         errors++;
         $display("FAIL dl_slot got=%b/%b exp=1/10", out_valid[0], out_data[1:0]);
      end
      out_ready = 4'b0001;
      tick();
      out_ready = 4'b0000;
   endtask

   task automatic test_reset_mid();
      out_ready = 4'b0000; in_valid = 1'b1;
      decider = 2'd0; in_data = 2'b01; tick();
      decider = 2'd2; in_data = 2'b11; tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 4'b0101) begin errors++; $display("FAIL mid_fill got=%b exp=0101", out_valid); end
      out_ready = 4'b1111; reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_reset got=%b exp=0000", out_valid); end
`ifdef DEMUX_COUNT_EN
      checks++;
      if (out_count !== 32'h0) begin errors++; $display("FAIL mid_count got=%h exp=0", out_count); end
`endif
      tick();
      out_ready = 4'b0000;
      checks++;
      if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_after got=%b exp=0000", out_valid); end
   endtask

   task automatic test_count_wrap();
      decider = 2'd1; out_ready = 4'b0010; in_valid = 1'b1;
      for (int k = 0; k < 257; k++) begin
         in_data = 2'(k);
         tick();
      end
      in_valid = 1'b0;
      tick();
      out_ready = 4'b0000;
      checks++;
      if (out_valid !== 4'b0000) begin errors++; $display("FAIL wrap_valid got=%b exp=0000", out_valid); end
`ifdef DEMUX_COUNT_EN
      checks++;
      if (out_count !== 32'h0000_0100) begin errors++; $display("FAIL wrap_count got=%h exp=00000100", out_count); end
`endif
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         in_valid  = 1'($urandom_range(0, 1));
         decider   = 2'($urandom_range(0, 3));
         in_data   = 2'($urandom_range(0, 3));
         out_ready = 4'($urandom_range(0, 15));
         tick();
      end
      in_valid = 1'b0; out_ready = 4'b1111;
      tick();
      tick();
      out_ready = 4'b0000;
      checks++;
      if (out_valid !== 4'b0000) begin errors++; $display("FAIL rand_end_valid got=%b exp=0000", out_valid); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sbq[i].size() != 0) begin
            errors++;
            $display("FAIL rand_leftover ch=%0d got=%0d exp=0", i, sbq[i].size());
         end
      end
`ifdef DEMUX_COUNT_EN
      checks++;
      if (out_count !== {mcnt[3], mcnt[2], mcnt[1], mcnt[0]}) begin
         errors++;
         $display("FAIL rand_count got=%h exp=%h", out_count, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_route();
      test_streaming();
      test_drain_and_load();
      test_reset_mid();
      test_count_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
